ycr_imem_wb_bridge: RTL and testbench

- Downstream of the instruction memory router: consumes one router port (imem req/ack/resp protocol) and converts each fetch into Wishbone classic read cycles on an external instruction bus.
- Handles burst fetches of imem_bl words: one Wishbone beat per word, one imem response per beat.
- Exactly one request outstanding at a time.

---
 rtl/ycr_imem_wb_bridge.sv | 137 +++++++++++++
 tb/tb_ycr_imem_wb_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ycr_imem_wb_bridge.sv
// Converts imem fetch requests into Wishbone classic read cycles, one beat per burst word.
// Optional watchdog on stalled beats: define YCR_IMEM_WB_TIMEOUT_EN.
module ycr_imem_wb_bridge #(
  parameter int AWIDTH         = 32,
  parameter int DWIDTH         = 32,
  parameter int BSIZE          = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_ack,
  input  logic                  imem_req,
  input  logic                  imem_cmd,
  input  logic [AWIDTH-1:0]     imem_addr,
  input  logic [BSIZE-1:0]      imem_bl,
  output logic [DWIDTH-1:0]     imem_rdata,
  output logic [1:0]            imem_resp,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [AWIDTH-1:0]     wbm_adr_o,
  output logic [DWIDTH/8-1:0]   wbm_sel_o,
  input  logic [DWIDTH-1:0]     wbm_dat_i,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUS     = 3'd1,
    S_RESP_OK = 3'd2,
    S_RESP_ER = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  localparam logic [AWIDTH-1:0] STRIDE = AWIDTH'(DWIDTH / 8);

  state_t              r_state;
  state_t              w_next;
  logic [AWIDTH-1:0]   r_addr;
  logic [BSIZE-1:0]    r_remain;
  logic [DWIDTH-1:0]   r_rdata;
  logic                w_accept;
  logic                w_timeout;

  assign w_accept = imem_req && (r_state == S_IDLE);

`ifdef YCR_IMEM_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;

  // Counts stalled BUS cycles; leaving BUS clears it so each beat starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (r_state != S_BUS) begin
      r_tmo <= '0;
    end else if (!wbm_ack_i && !wbm_err_i) begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

  assign w_timeout = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out: a stalled beat waits forever.
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = imem_cmd ? S_ERR : S_BUS;
      S_BUS: begin
        if (wbm_err_i)      w_next = S_RESP_ER;
        else if (wbm_ack_i) w_next = S_RESP_OK;
        else if (w_timeout) w_next = S_RESP_ER;
      end
      S_RESP_OK: w_next = (r_remain == BSIZE'(1)) ? S_IDLE : S_BUS;
      S_RESP_ER: w_next = S_IDLE;
      S_ERR:     w_next = S_RESP_ER;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_ack = 1'b0;
    wbm_cyc_o    = 1'b0;
    wbm_stb_o    = 1'b0;
    wbm_sel_o    = '0;
    imem_resp    = 2'd0;
    case (r_state)
      S_IDLE:    imem_req_ack = 1'b1;
      S_BUS: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = '1;
      end
      S_RESP_OK: imem_resp = 2'd1;
      S_RESP_ER: imem_resp = 2'd2;
      default:   imem_resp = 2'd0;
    endcase
  end

  assign wbm_we_o   = 1'b0;
  assign wbm_adr_o  = r_addr;
  assign imem_rdata = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (w_accept) begin
      r_addr   <= imem_addr;
      r_remain <= (imem_bl == '0) ? BSIZE'(1) : imem_bl;
    end else if (r_state == S_RESP_OK) begin
      r_addr   <= r_addr + STRIDE;
      r_remain <= r_remain - BSIZE'(1);
    end
  end

  // Error responses always carry zero data, whatever the bus returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if ((w_next == S_RESP_ER) && (r_state != S_RESP_ER)) begin
      r_rdata <= '0;
    end else if ((r_state == S_BUS) && wbm_ack_i) begin
      r_rdata <= wbm_dat_i;
    end
  end

endmodule

// File: tb/tb_ycr_imem_wb_bridge.sv
// Bench for ycr_imem_wb_bridge: directed vector table plus random fetches against a
// transaction-level model of beat addresses, response codes and response timing.
module tb_ycr_imem_wb_bridge;

  localparam int TMO = 8;
`ifdef YCR_IMEM_WB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_ack;
  logic        imem_req;
  logic        imem_cmd;
  logic [31:0] imem_addr;
  logic [2:0]  imem_bl;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  ycr_imem_wb_bridge #(.AWIDTH(32), .DWIDTH(32), .BSIZE(3), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_ack(imem_req_ack), .imem_req(imem_req), .imem_cmd(imem_cmd),
    .imem_addr(imem_addr), .imem_bl(imem_bl), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o),
    .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       addr;
    logic [2:0]        bl;
    logic              cmd;
    logic [7:0][7:0]   w;          // wait states per beat
    logic [7:0][31:0]  d;          // slave data per beat
    logic [3:0]        err_beat;   // 8 = no error
    logic              both;       // ack together with err
    logic [3:0]        abort_beat; // 8 = no reset
    logic              hold_req;   // keep req high into the last response
    logic [3:0]        exp_nresp;
    logic [1:0]        exp_last_rc;
  } txn_t;

  int checks = 0;
  int failures = 0;

  int          e_s[8], e_a[8], e_r[8];
  logic [31:0] e_adr[8], e_rd[8];
  logic [1:0]  e_rc[8];
  int          e_n, e_nbus, e_last;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Timeline from the latency rules: stb one cycle after accept, response one cycle
  // after the terminating ack/err, next stb the cycle after that response.
  function automatic void model(input txn_t t);
    int s, w, n;
    bit to;
    e_n = 0; e_nbus = 0; s = 1;
    if (t.cmd) begin
      e_rc[0] = 2'd2; e_rd[0] = '0; e_r[0] = 2; e_n = 1; e_last = 2;
      return;
    end
    n = (t.bl == 3'd0) ? 1 : int'(t.bl);
    for (int i = 0; i < n; i++) begin
      e_adr[i] = t.addr + 32'(4 * i);
      e_s[i]   = s;
      e_nbus   = i + 1;
      if (i == int'(t.abort_beat)) begin
        e_a[i] = 1 << 20; e_last = s;
        return;
      end
      w = int'(t.w[i]); to = 1'b0;
      if (TMO_EN && w >= TMO) begin w = TMO - 1; to = 1'b1; end
      e_a[i] = s + w; e_r[i] = s + w + 1; e_n = i + 1; e_last = s + w + 1;
      if (to || i == int'(t.err_beat)) begin
        e_rc[i] = 2'd2; e_rd[i] = '0;
        return;
      end
      e_rc[i] = 2'd1; e_rd[i] = t.d[i];
      s = s + w + 2;
    end
  endfunction

  function automatic txn_t mk(logic [31:0] a, logic [2:0] bl, logic cmd, int wt, int eb,
                              logic both, int ab, logic hold, int nr, int lrc);
    txn_t t;
    t.addr = a; t.bl = bl; t.cmd = cmd;
    for (int i = 0; i < 8; i++) begin
      t.w[i] = 8'(wt);
      t.d[i] = $urandom;
    end
    t.err_beat = 4'(eb); t.both = both; t.abort_beat = 4'(ab); t.hold_req = hold;
    t.exp_nresp = 4'(nr); t.exp_last_rc = 2'(lrc);
    return t;
  endfunction

  // Entered and left at a negedge of an IDLE cycle.
  task automatic run_txn(input txn_t t);
    int cnt, sb, nresp, bi, ri;
    logic [1:0] lrc, exp_rc;
    logic exp_stb;
    bit aborted;
    cnt = 0; sb = 0; nresp = 0; lrc = 2'd0; aborted = 1'b0;
    model(t);
    chk("idle_req_ack", 32'(imem_req_ack), 32'd1);
    chk("idle_resp", 32'(imem_resp), 32'd0);
    imem_req = 1'b1; imem_addr = t.addr; imem_bl = t.bl; imem_cmd = t.cmd;
    for (int c = 1; c <= e_last; c++) begin
      @(negedge clk);
      imem_req = 1'b0; imem_addr = $urandom; imem_bl = 3'($urandom); imem_cmd = 1'($urandom);
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
      exp_stb = 1'b0; bi = 0;
      for (int i = 0; i < e_nbus; i++)
        if (c >= e_s[i] && c <= e_a[i]) begin exp_stb = 1'b1; bi = i; end
      exp_rc = 2'd0; ri = 0;
      for (int i = 0; i < e_n; i++)
        if (c == e_r[i]) begin exp_rc = e_rc[i]; ri = i; end
      chk("stb", 32'(wbm_stb_o), 32'(exp_stb));
      chk("cyc", 32'(wbm_cyc_o), 32'(exp_stb));
      chk("busy_req_ack", 32'(imem_req_ack), 32'd0);
      chk("resp", 32'(imem_resp), 32'(exp_rc));
      if (exp_stb) begin
        chk("adr", wbm_adr_o, e_adr[bi]);
        chk("sel", 32'(wbm_sel_o), 32'hF);
        chk("we", 32'(wbm_we_o), 32'd0);
      end
      if (exp_rc != 2'd0) chk("rdata", imem_rdata, e_rd[ri]);
      if (imem_resp != 2'd0) begin nresp++; lrc = imem_resp; end
      if (t.abort_beat < 4'd8 && c == e_last) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_resp", 32'(imem_resp), 32'd0);
        chk("rst_rdata", imem_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (wbm_stb_o && sb < 8) begin
        if (cnt == int'(t.w[sb])) begin
          if (sb == int'(t.err_beat)) begin
            wbm_err_i = 1'b1; wbm_ack_i = t.both;
          end else begin
            wbm_ack_i = 1'b1; wbm_dat_i = t.d[sb];
          end
          sb++; cnt = 0;
        end else cnt++;
      end else cnt = 0;
      if (t.hold_req && c == e_last) imem_req = 1'b1;
    end
    if (!aborted) begin
      @(negedge clk);
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      chk("end_req_ack", 32'(imem_req_ack), 32'd1);
      chk("end_resp", 32'(imem_resp), 32'd0);
      chk("end_stb", 32'(wbm_stb_o), 32'd0);
    end
    chk("nresp", 32'(nresp), 32'(t.exp_nresp));
    chk("last_rc", 32'(lrc), 32'(t.exp_last_rc));
  endtask

  txn_t vec[$];
  txn_t tx;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_req = 1'b0; imem_cmd = 1'b0; imem_addr = '0; imem_bl = '0;
    wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_resp", 32'(imem_resp), 32'd0);
    chk("reset_rdata", imem_rdata, 32'd0);
    chk("reset_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("reset_stb", 32'(wbm_stb_o), 32'd0);
    chk("reset_adr", wbm_adr_o, 32'd0);
    chk("reset_req_ack", 32'(imem_req_ack), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    //          addr          bl cmd wt eb both ab hold nresp lrc
    tx = mk(32'h0000_1000, 3'd1, 1'b0, 1, 8, 1'b0, 8, 1'b0, 1, 1);
    tx.d[0] = 32'hDEAD_BEEF; vec.push_back(tx);
    tx = mk(32'h0000_2000, 3'd4, 1'b0, 2, 8, 1'b0, 8, 1'b0, 4, 1);
    tx.d[0] = 32'h11; tx.d[1] = 32'h22; tx.d[2] = 32'h33; tx.d[3] = 32'h44; vec.push_back(tx);
    vec.push_back(mk(32'h0000_3000, 3'd4, 1'b0, 0, 1, 1'b0, 8, 1'b0, 2, 2));
    vec.push_back(mk(32'h0000_3100, 3'd2, 1'b1, 0, 8, 1'b0, 8, 1'b0, 1, 2));
    vec.push_back(mk(32'hFFFF_FFFC, 3'd2, 1'b0, 0, 8, 1'b0, 8, 1'b0, 2, 1));
    vec.push_back(mk(32'h0000_0040, 3'd0, 1'b0, 0, 8, 1'b0, 8, 1'b0, 1, 1));
    vec.push_back(mk(32'h0000_5000, 3'd3, 1'b0, 1, 0, 1'b1, 8, 1'b0, 1, 2));
    vec.push_back(mk(32'h0000_0600, 3'd1, 1'b0, 0, 8, 1'b0, 8, 1'b1, 1, 1));
    vec.push_back(mk(32'h0000_0700, 3'd2, 1'b0, 0, 8, 1'b0, 8, 1'b0, 2, 1));
    vec.push_back(mk(32'h0000_8000, 3'd4, 1'b0, 0, 8, 1'b0, 1, 1'b0, 1, 1));
    vec.push_back(mk(32'h0000_9000, 3'd1, 1'b0, 0, 8, 1'b0, 8, 1'b0, 1, 1));
`ifdef YCR_IMEM_WB_TIMEOUT_EN
    vec.push_back(mk(32'h0000_A000, 3'd2, 1'b0, 20, 8, 1'b0, 8, 1'b0, 1, 2));
`endif
    foreach (vec[k]) run_txn(vec[k]);

    for (int k = 0; k < 40; k++) begin
      tx = mk(($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                           : ($urandom & 32'hFFFF_FFFC),
              3'($urandom), ($urandom_range(0, 7) == 0), 0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 8,
              1'($urandom), 8, (k < 39) ? 1'($urandom) : 1'b0, 0, 0);
      for (int i = 0; i < 8; i++) tx.w[i] = 8'($urandom_range(0, 3));
      model(tx);
      tx.exp_nresp = 4'(e_n);
      tx.exp_last_rc = e_rc[e_n - 1];
      run_txn(tx);
    end
    imem_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
